// File: rtl/rgb_mode_pwm_ctrl.sv
// Button-stepped LED brightness controller: OFF, static levels and a PARTY ramp,
// driving CH PWM channels that share one free-running period counter.
module rgb_mode_pwm_ctrl #(
    parameter int CH        = 3,
    parameter int DW        = 10,
    parameter int LEVELS    = 3,
    parameter int STEP_DIV  = 100000,
    parameter int STEP_BASE = 64
) (
    input  logic          clk,
    input  logic          reset_p,
    input  logic          btn,
    output logic [3:0]    mode_o,
    output logic          party_mode_flag,
    output logic [CH-1:0] pwm_out
);

    localparam int TW = $clog2(STEP_DIV);
    localparam int SW = DW + $clog2(CH + 1) + 1;
    localparam int LW = DW + 4;
    localparam logic [DW-1:0] DMAX  = {DW{1'b1}};
    localparam logic [DW-1:0] HALF  = DW'(2 ** (DW - 1));
    localparam logic [3:0]    PARTY = 4'(LEVELS + 1);

    logic [DW-1:0] level_duty [16];

    for (genvar k = 0; k < 16; k++) begin : g_level
        localparam logic [DW-1:0] DUTY =
            (k <= LEVELS) ? DW'((LW'(k) * LW'(DMAX)) / LW'(LEVELS)) : '0;
        assign level_duty[k] = DUTY;
    end

    logic          sync1_q, sync2_q, prev_q, armed_q;
    logic [1:0]    fill_q;
    logic [3:0]    mode_q, mode_d;
    logic          party_q;
    logic [TW-1:0] tick_q, tick_d;
    logic [DW-1:0] tgt_q [CH];
    logic [DW-1:0] tgt_d [CH];
    logic [DW-1:0] act_q [CH];
    logic [DW-1:0] cnt_q;
    logic [CH-1:0] pwm_q;
    logic          rise, tick;
    logic [SW-1:0] sum;

    // armed_q only sets once sync2_q holds a genuinely sampled low, so a level
    // held high through reset is never taken as a press.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            fill_q  <= {fill_q[0], 1'b1};
            if (fill_q[1] && !sync2_q) armed_q <= 1'b1;
        end
    end

    assign rise = sync2_q & ~prev_q & armed_q;
    assign tick = (mode_q == PARTY) && (tick_q == TW'(STEP_DIV - 1));

    always_comb begin
        mode_d = mode_q;
        tick_d = tick_q;
        tgt_d  = tgt_q;
        sum    = '0;
        if (rise) begin
            mode_d = (mode_q == PARTY) ? 4'd0 : mode_q + 4'd1;
            tick_d = '0;
            for (int c = 0; c < CH; c++) begin
                if (mode_d == PARTY) tgt_d[c] = (c == 0) ? HALF : '0;
                else                 tgt_d[c] = level_duty[mode_d];
            end
        end else if (mode_q == PARTY) begin
            if (tick) begin
                tick_d = '0;
                for (int c = 0; c < CH; c++) begin
                    sum      = SW'(tgt_q[c]) + SW'((c + 1) * STEP_BASE);
                    tgt_d[c] = (sum > SW'(DMAX)) ? '0 : sum[DW-1:0];
                end
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            mode_q  <= '0;
            party_q <= 1'b0;
            tick_q  <= '0;
            cnt_q   <= '0;
            pwm_q   <= '0;
            for (int c = 0; c < CH; c++) begin
                tgt_q[c] <= '0;
                act_q[c] <= '0;
            end
        end else begin
            mode_q  <= mode_d;
            party_q <= (mode_d == PARTY);
            tick_q  <= tick_d;
            cnt_q   <= cnt_q + DW'(1);
            for (int c = 0; c < CH; c++) begin
                tgt_q[c] <= tgt_d[c];
                // shadow load only at period boundary keeps every period whole
                if (cnt_q == DMAX) act_q[c] <= tgt_q[c];
                pwm_q[c] <= (cnt_q < act_q[c]);
            end
        end
    end

    assign mode_o          = mode_q;
    assign party_mode_flag = party_q;
    assign pwm_out         = pwm_q;

endmodule

// File: tb/tb_rgb_mode_pwm_ctrl.sv
// Bench for rgb_mode_pwm_ctrl: randomized button presses checked against a
// mode/duty model; duty is measured as high-cycle counts over whole PWM periods.
module tb_rgb_mode_pwm_ctrl;

    localparam int CH        = 3;
    localparam int DW        = 4;
    localparam int LEVELS    = 3;
    localparam int STEP_DIV  = 4;
    localparam int STEP_BASE = 2;
    localparam int DMAX      = (1 << DW) - 1;
    localparam int PER       = 1 << DW;
    localparam int PARTY_M   = LEVELS + 1;
    localparam int NMODES    = LEVELS + 2;

    logic          clk = 1'b0;
    logic          reset_p = 1'b1;
    logic          btn = 1'b0;
    logic [3:0]    mode_o;
    logic          party_mode_flag;
    logic [CH-1:0] pwm_out;

    int cyc;
    int n_checks = 0;
    int n_fail   = 0;
    int m_mode     = 0;
    int change_cyc = 0;
    int party_cyc  = 0;

    rgb_mode_pwm_ctrl #(
        .CH(CH), .DW(DW), .LEVELS(LEVELS), .STEP_DIV(STEP_DIV), .STEP_BASE(STEP_BASE)
    ) dut (
        .clk(clk),
        .reset_p(reset_p),
        .btn(btn),
        .mode_o(mode_o),
        .party_mode_flag(party_mode_flag),
        .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    // time reference: number of clock edges since reset release
    always @(posedge clk or posedge reset_p) begin
        if (reset_p) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    function automatic int ramp(input int c, input int start, input int n);
        int d;
        d = start;
        for (int i = 0; i < n; i++) begin
            d = d + (c + 1) * STEP_BASE;
            if (d > DMAX) d = 0;
        end
        return d;
    endfunction

    // duty of the period whose shadow load happens at the clock edge numbered w
    function automatic int expected_duty(input int c, input int w);
        if (m_mode == 0) return 0;
        if (m_mode <= LEVELS) return (m_mode * DMAX) / LEVELS;
        return ramp(c, (c == 0) ? (1 << (DW - 1)) : 0, (w - 1 - party_cyc) / STEP_DIV);
    endfunction

    task automatic wait_phase(input int md, input int rem, input int min_cyc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4 * PER; i++) begin
            if (cyc % md == rem && cyc >= min_cyc) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_phase: cyc=%0d never reached phase %0d mod %0d", cyc, rem, md);
        end
    endtask

    task automatic measure(input string name);
        int w;
        int hi [CH];
        bit ok;
        ok = 1'b0;
        w  = 0;
        for (int i = 0; i < 4 * PER; i++) begin
            @(negedge clk);
            if (cyc % PER == 0 && cyc - 1 >= change_cyc) begin
                ok = 1'b1;
                w  = cyc;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_align: no period boundary after cyc %0d", name, change_cyc);
        end else begin
            for (int c = 0; c < CH; c++) hi[c] = 0;
            for (int i = 0; i < PER; i++) begin
                @(negedge clk);
                for (int c = 0; c < CH; c++) if (pwm_out[c] === 1'b1) hi[c]++;
            end
            for (int c = 0; c < CH; c++) begin
                n_checks++;
                if (hi[c] !== expected_duty(c, w)) begin
                    n_fail++;
                    $display("FAIL %s ch%0d mode %0d: high %0d of %0d cycles, required %0d",
                             name, c, m_mode, hi[c], PER, expected_duty(c, w));
                end
            end
        end
    endtask

    // caller is at a negedge; btn rises now and stays high for 'hold' cycles
    task automatic press(input int hold, input string name);
        int  start;
        int  old;
        bit  bad;
        old   = m_mode;
        btn   = 1'b1;
        start = cyc;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i == hold) btn = 1'b0;
            if (i == 2) begin
                n_checks++;
                if (mode_o !== 4'(old)) begin
                    n_fail++;
                    $display("FAIL %s_early: mode_o=%0d after 2 edges, required %0d", name, mode_o, old);
                end
            end
        end
        m_mode     = (old + 1) % NMODES;
        change_cyc = start + 3;
        if (m_mode == PARTY_M) party_cyc = start + 3;
        n_checks++;
        if (mode_o !== 4'(m_mode)) begin
            n_fail++;
            $display("FAIL %s_mode: mode_o=%0d, required %0d", name, mode_o, m_mode);
        end
        n_checks++;
        if (party_mode_flag !== (m_mode == PARTY_M)) begin
            n_fail++;
            $display("FAIL %s_flag: party_mode_flag=%0b, required %0b", name, party_mode_flag,
                     (m_mode == PARTY_M));
        end
        bad = 1'b0;
        for (int i = 4; i <= hold; i++) begin
            @(negedge clk);
            if (mode_o !== 4'(m_mode)) bad = 1'b1;
            if (i == hold) btn = 1'b0;
        end
        if (hold > 3) begin
            n_checks++;
            if (bad) begin
                n_fail++;
                $display("FAIL %s_hold: mode_o=%0d moved while btn held, required %0d", name, mode_o, m_mode);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_p = 1'b1;
        btn     = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (mode_o !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mode: mode_o=%0d, required 0", mode_o);
        end
        n_checks++;
        if (party_mode_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flag: party_mode_flag=%0b, required 0", party_mode_flag);
        end
        n_checks++;
        if (pwm_out !== '0) begin
            n_fail++;
            $display("FAIL reset_pwm: pwm_out=%b, required 000", pwm_out);
        end
        reset_p    = 1'b0;
        m_mode     = 0;
        change_cyc = 0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_checks++;
            if (mode_o !== 4'd0 || pwm_out !== '0 || party_mode_flag !== 1'b0) begin
                n_fail++;
                $display("FAIL idle cyc %0d: mode_o=%0d pwm_out=%b flag=%0b, required 0/000/0",
                         cyc, mode_o, pwm_out, party_mode_flag);
            end
        end
    endtask

    task automatic test_mode_walk();
        press(100, "press1");
        measure("level1");
        press(1 + int'($urandom % 3), "press2");
        measure("level2");
        press(1 + int'($urandom % 3), "press3");
        measure("level3");
        // entry lands on the last edge before a wrap: first party period is unramped
        wait_phase(PER, PER - 4, 0);
        press(1, "press4_party");
        measure("party_first");
        repeat (4) measure("party_ramp");
        press(2, "press5_off");
        measure("off_again");
    endtask

    task automatic test_tick_collision();
        while (m_mode != PARTY_M) press(1 + int'($urandom % 4), "to_party");
        // press so that the mode change edge is also a ramp tick edge
        wait_phase(STEP_DIV, (party_cyc + 1) % STEP_DIV, party_cyc + 5);
        press(1, "collide");
        measure("collide_off");
    endtask

    task automatic test_random_presses();
        for (int n = 0; n < 16; n++) begin
            repeat (int'($urandom_range(0, 20))) @(negedge clk);
            press(1 + int'($urandom % 6), "rand_press");
            measure("rand_duty");
        end
    endtask

    task automatic test_reset_mid_party();
        while (m_mode != PARTY_M) press(1 + int'($urandom % 4), "to_party2");
        repeat (5) @(negedge clk);
        btn = 1'b1;
        repeat (int'($urandom_range(3, 12))) @(negedge clk);
        #2 reset_p = 1'b1;
        #1;
        n_checks++;
        if (mode_o !== 4'd0 || party_mode_flag !== 1'b0 || pwm_out !== '0) begin
            n_fail++;
            $display("FAIL reset_async: mode_o=%0d flag=%0b pwm_out=%b, required 0/0/000",
                     mode_o, party_mode_flag, pwm_out);
        end
        repeat (3) @(negedge clk);
        reset_p    = 1'b0;
        m_mode     = 0;
        change_cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (mode_o !== 4'd0 || pwm_out !== '0) begin
                n_fail++;
                $display("FAIL held_btn cyc %0d: mode_o=%0d pwm_out=%b, required 0/000", cyc, mode_o, pwm_out);
            end
        end
        btn = 1'b0;
        repeat (3) @(negedge clk);
        press(1, "after_reset");
        measure("after_reset_duty");
    endtask

    initial begin
        test_reset();
        test_idle();
        test_mode_walk();
        test_tick_collision();
        test_random_presses();
        test_reset_mid_party();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
